periph_arbiter: RTL and testbench
=================================

# periph_arbiter

Round-robin arbiter sharing one 2-bit send/ack peripheral port among NREQ CPU-side requesters. Each requester runs the same four-phase handshake (send up, ack up, send down, ack down) that a CPU uses toward the peripheral. The arbiter multiplexes these handshakes onto the single downstream port, one complete transaction at a time. It sits between the CPU FSMs and the peripheral FSM, all in one clock domain.

## Interface
- NREQ, 2, number of requesters; legal range 2..4.
- CW, 8, width of the completed-transfer counter.

- clk1  in  1  clock; all logic on the rising edge.
- rst1  in  1  asynchronous, active-high reset.
- send_i  in  NREQ  per-requester send request; level, held until acknowledged.
- dado_i  in  2*NREQ  per-requester data; requester k uses bits [2k+1:2k].
- ack_o  out  NREQ  per-requester acknowledge.
- send  out  1  downstream send to the peripheral.
- dado  out  2  downstream data, latched at grant.
- ack  in  1  downstream acknowledge from the peripheral.
- gnt_id  out  2  index of the requester currently or last granted.
- busy  out  1  high in every state except IDLE.
- xfer_count  out  CW  completed transactions; wraps modulo 2^CW.

## Operation
- States are IDLE, REQ, ACKD and REL. All outputs are registered.
- **IDLE:** if ack==0 and any send_i is high, choose requester k by round-robin, then:
  - go to REQ;
  - set send=1 and dado=dado_i[k], and set gnt_id=k;
  - set ptr=(k+1) mod NREQ.
- **IDLE, blocked:** while ack==1 (a stale ack, for example after a reset), no grant is issued.
- **Round-robin rule:** search starts at ptr and wraps upward. With a single requester active, that requester always wins.
- **REQ:** wait for ack==1, then go to ACKD and set ack_o[k]=1.
  - send_i[k] is ignored in REQ. A requester that drops send before ack still gets its transaction completed.
- **ACKD:** wait for send_i[k]==0, then go to REL, set ack_o[k]=0 and set send=0.
- **REL:** wait for ack==0, then go to IDLE and increment xfer_count.
- **Requests outside IDLE:** send_i from other requesters, or a re-raised send_i[k], is held off until IDLE. Requests are never lost, since they are level-held.
- **Data capture:** dado is latched only on the IDLE to REQ transition. Changes on dado_i after the grant are ignored.
- **ack_o:** at most one bit is high at any time.
- **Reset (any time, including mid-transaction):** state=IDLE, send=0, dado=0, ack_o=0, gnt_id=0, busy=0, xfer_count=0, ptr=0.

## Timing
- The sampling edge is edge 0. Each step below is one clock edge after the input condition is seen:
  - edge 1: send_i[k] seen in IDLE gives send=1.
  - ack seen high in REQ gives ack_o[k]=1.
  - send_i[k] seen low in ACKD gives send=0 and ack_o[k]=0.
  - ack seen low in REL gives IDLE and xfer_count+1.
- A new grant can occur at the edge after returning to IDLE. The IDLE-to-IDLE minimum is 4 cycles with an immediately responding peripheral and requester.
- Simultaneous requests in IDLE: exactly one grant, following round-robin order.
- xfer_count wraps from 2^CW-1 to 0 with no flag.

## Structure
- Shared include periph_arb_defs.v holds:
  - state encodings ST_IDLE=2'd0, ST_REQ=2'd1, ST_ACKD=2'd2, ST_REL=2'd3;
  - the NREQ range check.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[NREQ-1:0] and ptr[1:0].
  - Outputs: valid and idx[1:0].
- The top level holds the FSM, the data latch, the ack demux and the counter.

## Test plan
- **Single request:** NREQ=2, send_i=2'b01, dado_i[1:0]=2'b10, peripheral acks after 3 cycles.
  - Response: send=1 one cycle after send_i; dado=2'b10; gnt_id=0.
  - Response: ack_o=2'b01 one cycle after ack; send=0 one cycle after send_i drops.
  - Response: xfer_count=1 after ack drops.
- **Contention:** send_i=2'b11 held continuously, requesters re-raising immediately after each handshake.
  - Response: grants alternate 0,1,0,1; ack_o is never 2'b11; xfer_count=4 after four handshakes.
- **Data stability:** requester 1 changes dado_i from 2'b01 to 2'b11 while in REQ.
  - Response: dado stays 2'b01 until REL.
- **Early drop:** send_i[0] dropped before ack.
  - Response: ack_o[0] pulses for 1 cycle, REL is entered, and xfer_count increments.
- **Reset mid-transaction:** rst1 asserted in ACKD while the peripheral holds ack=1.
  - Response: all outputs are 0 immediately.
  - Response: no grant while ack=1; grant to requester 0 one cycle after ack falls.
- **Counter wrap:** CW=2, five transactions.
  - Response: xfer_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/periph_arbiter_pkg.sv
// periph_arbiter_pkg: state encoding and requester-count limits shared by the arbiter files
package periph_arbiter_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACKD = 2'd2,
        ST_REL  = 2'd3
    } state_t;
    localparam int NREQ_MIN = 2;
    localparam int NREQ_MAX = 4;
endpackage

// File: rtl/periph_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, search starts at ptr and wraps upward
module rr_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic            valid,
    output logic [1:0]      idx
);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int                off;
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[NREQ-1:0];
        off = 0;
        for (int o = NREQ - 1; o >= 0; o--) off = rot[o] ? o : off;
        valid = |req;
        idx = 2'((int'(ptr) + off) % NREQ);
    end
endmodule

// File: rtl/periph_arbiter.sv
// periph_arbiter: round-robin sharing of one four-phase send/ack peripheral port among NREQ requesters
module periph_arbiter
    import periph_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int CW   = 8
) (
    input  logic              clk1,
    input  logic              rst1,
    input  logic [NREQ-1:0]   send_i,
    input  logic [2*NREQ-1:0] dado_i,
    output logic [NREQ-1:0]   ack_o,
    output logic              send,
    output logic [1:0]        dado,
    input  logic              ack,
    output logic [1:0]        gnt_id,
    output logic              busy,
    output logic [CW-1:0]     xfer_count
);
    if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_nreq_check
        $error("periph_arbiter: NREQ must be in 2..4");
    end
    state_t            st;
    logic [1:0]        ptr;
    logic              valid;
    logic [1:0]        idx;
    logic [NREQ-1:0]   gmask;
    logic              gsend;
    logic [2*NREQ-1:0] dsh;
    rr_pick #(.NREQ(NREQ)) u_pick (
        .req  (send_i),
        .ptr  (ptr),
        .valid(valid),
        .idx  (idx)
    );
    always_comb begin
        gmask = NREQ'(1) << gnt_id;
        gsend = |(send_i & gmask);
        dsh = dado_i >> {idx, 1'b0};
    end
    always_ff @(posedge clk1 or posedge rst1) begin
        if (rst1) begin
            st         <= ST_IDLE;
            send       <= 1'b0;
            dado       <= 2'd0;
            ack_o      <= '0;
            gnt_id     <= 2'd0;
            busy       <= 1'b0;
            xfer_count <= '0;
            ptr        <= 2'd0;
        end else begin
            case (st)
                ST_IDLE: if (!ack && valid) begin
                    st     <= ST_REQ;
                    busy   <= 1'b1;
                    send   <= 1'b1;
                    dado   <= dsh[1:0];
                    gnt_id <= idx;
                    ptr    <= (int'(idx) == NREQ - 1) ? 2'd0 : idx + 2'd1;
                end
                ST_REQ: if (ack) begin
                    st    <= ST_ACKD;
                    ack_o <= gmask;
                end
                ST_ACKD: if (!gsend) begin
                    st    <= ST_REL;
                    ack_o <= '0;
                    send  <= 1'b0;
                end
                default: if (!ack) begin
                    st         <= ST_IDLE;
                    busy       <= 1'b0;
                    xfer_count <= xfer_count + CW'(1);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_periph_arbiter.sv
// tb_periph_arbiter: randomized and directed checks of periph_arbiter against a round-robin reference model
module tb_periph_arbiter;
    localparam int NREQ = 2;
    logic       clk1 = 1'b0;
    logic       rst1 = 1'b1;
    logic [1:0] send_i = '0;
    logic [3:0] dado_i = '0;
    logic       ack = 1'b0;
    logic [1:0] ack_o, ack_o_w, dado, dado_w, gnt_id, gnt_id_w;
    logic       send, send_w, busy, busy_w;
    logic [7:0] xfer_count;
    logic [1:0] xfer_count_w;
    int n_checks = 0;
    int n_fail = 0;
    int m_last = NREQ - 1;
    int exp_cnt = 0;
    always #5 clk1 = ~clk1;
    periph_arbiter #(.NREQ(NREQ), .CW(8)) dut (
        .clk1(clk1), .rst1(rst1), .send_i(send_i), .dado_i(dado_i), .ack_o(ack_o),
        .send(send), .dado(dado), .ack(ack), .gnt_id(gnt_id), .busy(busy), .xfer_count(xfer_count)
    );
    periph_arbiter #(.NREQ(NREQ), .CW(2)) dut_w (
        .clk1(clk1), .rst1(rst1), .send_i(send_i), .dado_i(dado_i), .ack_o(ack_o_w),
        .send(send_w), .dado(dado_w), .ack(ack), .gnt_id(gnt_id_w), .busy(busy_w), .xfer_count(xfer_count_w)
    );
    always @(negedge clk1) begin
        if (!rst1) begin
            n_checks++;
            if ($countones(ack_o) > 1) begin
                n_fail++;
                $display("FAIL ack_o_onehot got %b want at most one bit", ack_o);
            end
        end
    end
    task automatic tick;
        @(posedge clk1);
        #1;
    endtask
    // reference: next winner is the first active requester after the last one granted
    function automatic int pick(input logic [1:0] req);
        for (int o = 1; o <= NREQ; o++) begin
            int j = (m_last + o) % NREQ;
            if (req[j]) return j;
        end
        return -1;
    endfunction
    task automatic do_reset;
        rst1 = 1'b1;
        send_i = '0;
        ack = 1'b0;
        dado_i = '0;
        tick();
        tick();
        rst1 = 1'b0;
        m_last = NREQ - 1;
        exp_cnt = 0;
    endtask
    task automatic test_reset;
        rst1 = 1'b1;
        tick();
        n_checks++;
        if ({send, dado, ack_o, gnt_id, busy} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b want 0", {send, dado, ack_o, gnt_id, busy});
        end
        n_checks++;
        if (xfer_count !== 8'd0 || xfer_count_w !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_count got %0d/%0d want 0/0", xfer_count, xfer_count_w);
        end
        rst1 = 1'b0;
        tick();
        n_checks++;
        if (send !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req got send=%b busy=%b want 0 0", send, busy);
        end
    endtask
    task automatic test_single;
        send_i = 2'b01;
        dado_i = 4'b0010;
        tick();
        n_checks++;
        if (send !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_send got send=%b busy=%b want 1 1", send, busy);
        end
        n_checks++;
        if (dado !== 2'b10 || gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL single_grant got dado=%b gnt=%0d want 10 0", dado, gnt_id);
        end
        m_last = 0;
        repeat (3) tick();
        n_checks++;
        if ({send, ack_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL single_wait got %b want 100", {send, ack_o});
        end
        ack = 1'b1;
        tick();
        n_checks++;
        if (ack_o !== 2'b01) begin
            n_fail++;
            $display("FAIL single_ack_o got %b want 01", ack_o);
        end
        send_i = 2'b00;
        tick();
        n_checks++;
        if ({send, ack_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL single_release got %b want 000", {send, ack_o});
        end
        ack = 1'b0;
        tick();
        exp_cnt++;
        n_checks++;
        if (xfer_count !== 8'(exp_cnt) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_count got %0d busy=%b want %0d 0", xfer_count, busy, exp_cnt);
        end
    endtask
    task automatic test_contention;
        int g;
        logic [1:0] m;
        do_reset();
        send_i = 2'b11;
        dado_i = 4'($urandom);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 20 && send !== 1'b1; i++) tick();
            g = pick(send_i);
            m = 2'(1 << g);
            n_checks++;
            if (send !== 1'b1 || gnt_id !== 2'(g)) begin
                n_fail++;
                $display("FAIL contention_grant got send=%b gnt=%0d want 1 %0d", send, gnt_id, g);
            end
            m_last = g;
            ack = 1'b1;
            tick();
            n_checks++;
            if (ack_o !== m) begin
                n_fail++;
                $display("FAIL contention_ack_o got %b want %b", ack_o, m);
            end
            send_i = send_i & ~m;
            tick();
            n_checks++;
            if (send !== 1'b0) begin
                n_fail++;
                $display("FAIL contention_drop got send=%b want 0", send);
            end
            ack = 1'b0;
            send_i = 2'b11;
            tick();
            exp_cnt++;
            n_checks++;
            if (xfer_count !== 8'(exp_cnt) || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL contention_count got %0d busy=%b want %0d 0", xfer_count, busy, exp_cnt);
            end
        end
        send_i = 2'b00;
        tick();
    endtask
    task automatic test_data_stability;
        do_reset();
        send_i = 2'b10;
        dado_i = 4'b0100;
        for (int i = 0; i < 20 && send !== 1'b1; i++) tick();
        n_checks++;
        if (send !== 1'b1 || gnt_id !== 2'd1 || dado !== 2'b01) begin
            n_fail++;
            $display("FAIL stable_grant got send=%b gnt=%0d dado=%b want 1 1 01", send, gnt_id, dado);
        end
        m_last = 1;
        dado_i = 4'b1100;
        repeat (2) tick();
        n_checks++;
        if (dado !== 2'b01) begin
            n_fail++;
            $display("FAIL stable_req got dado=%b want 01", dado);
        end
        ack = 1'b1;
        tick();
        send_i = 2'b00;
        tick();
        n_checks++;
        if (dado !== 2'b01 || send !== 1'b0) begin
            n_fail++;
            $display("FAIL stable_rel got dado=%b send=%b want 01 0", dado, send);
        end
        ack = 1'b0;
        tick();
        exp_cnt++;
        n_checks++;
        if (xfer_count !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL stable_count got %0d want %0d", xfer_count, exp_cnt);
        end
    endtask
    task automatic test_early_drop;
        send_i = 2'b01;
        dado_i = 4'b0011;
        for (int i = 0; i < 20 && send !== 1'b1; i++) tick();
        n_checks++;
        if (send !== 1'b1 || gnt_id !== 2'(pick(2'b01))) begin
            n_fail++;
            $display("FAIL early_grant got send=%b gnt=%0d want 1 %0d", send, gnt_id, pick(2'b01));
        end
        m_last = 0;
        send_i = 2'b00;
        repeat (2) tick();
        n_checks++;
        if (send !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL early_hold got send=%b busy=%b want 1 1", send, busy);
        end
        ack = 1'b1;
        tick();
        n_checks++;
        if (ack_o !== 2'b01) begin
            n_fail++;
            $display("FAIL early_ack_o got %b want 01", ack_o);
        end
        tick();
        n_checks++;
        if ({ack_o, send, busy} !== 4'b0001) begin
            n_fail++;
            $display("FAIL early_rel got %b want 0001", {ack_o, send, busy});
        end
        ack = 1'b0;
        tick();
        exp_cnt++;
        n_checks++;
        if (xfer_count !== 8'(exp_cnt) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL early_count got %0d busy=%b want %0d 0", xfer_count, busy, exp_cnt);
        end
    endtask
    task automatic test_reset_mid;
        send_i = 2'b01;
        dado_i = 4'b0011;
        for (int i = 0; i < 20 && send !== 1'b1; i++) tick();
        ack = 1'b1;
        tick();
        n_checks++;
        if (ack_o !== 2'b01 || dado !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_ackd got ack_o=%b dado=%b want 01 11", ack_o, dado);
        end
        rst1 = 1'b1;
        #1;
        n_checks++;
        if ({send, dado, ack_o, gnt_id, busy} !== 8'd0 || xfer_count !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_async got %b cnt=%0d want 0 0", {send, dado, ack_o, gnt_id, busy}, xfer_count);
        end
        tick();
        rst1 = 1'b0;
        m_last = NREQ - 1;
        exp_cnt = 0;
        repeat (3) tick();
        n_checks++;
        if (send !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_stale_ack got send=%b busy=%b want 0 0", send, busy);
        end
        ack = 1'b0;
        tick();
        n_checks++;
        if (send !== 1'b1 || gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_regrant got send=%b gnt=%0d want 1 0", send, gnt_id);
        end
        m_last = 0;
        ack = 1'b1;
        tick();
        send_i = 2'b00;
        tick();
        ack = 1'b0;
        tick();
        exp_cnt++;
        n_checks++;
        if (xfer_count !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL mid_count got %0d want %0d", xfer_count, exp_cnt);
        end
    endtask
    task automatic test_wrap;
        int exp_w[5] = '{1, 2, 3, 0, 1};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send_i = 2'b01;
            for (int i = 0; i < 20 && send !== 1'b1; i++) tick();
            m_last = 0;
            ack = 1'b1;
            tick();
            send_i = 2'b00;
            tick();
            ack = 1'b0;
            tick();
            exp_cnt++;
            n_checks++;
            if (xfer_count_w !== 2'(exp_w[k]) || xfer_count !== 8'(exp_cnt)) begin
                n_fail++;
                $display("FAIL wrap_count got %0d/%0d want %0d/%0d", xfer_count_w, xfer_count, exp_w[k], exp_cnt);
            end
        end
    endtask
    task automatic test_random;
        int g;
        logic [1:0] m;
        logic [3:0] dsh;
        for (int k = 0; k < 40; k++) begin
            send_i = 2'($urandom_range(1, 3));
            dado_i = 4'($urandom);
            for (int i = 0; i < 20 && send !== 1'b1; i++) tick();
            g = pick(send_i);
            m = 2'(1 << g);
            dsh = dado_i >> (2 * g);
            n_checks++;
            if (send !== 1'b1 || gnt_id !== 2'(g) || dado !== dsh[1:0]) begin
                n_fail++;
                $display("FAIL rand_grant got send=%b gnt=%0d dado=%b want 1 %0d %b", send, gnt_id, dado, g, dsh[1:0]);
            end
            m_last = g;
            dado_i = 4'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            n_checks++;
            if ({send, ack_o, dado} !== {1'b1, 2'b00, dsh[1:0]}) begin
                n_fail++;
                $display("FAIL rand_req got %b want %b", {send, ack_o, dado}, {1'b1, 2'b00, dsh[1:0]});
            end
            ack = 1'b1;
            tick();
            repeat ($urandom_range(0, 2)) tick();
            n_checks++;
            if (ack_o !== m) begin
                n_fail++;
                $display("FAIL rand_ack_o got %b want %b", ack_o, m);
            end
            send_i = send_i & ~m;
            tick();
            n_checks++;
            if ({send, ack_o} !== 3'b000) begin
                n_fail++;
                $display("FAIL rand_drop got %b want 000", {send, ack_o});
            end
            repeat ($urandom_range(0, 2)) tick();
            ack = 1'b0;
            tick();
            exp_cnt++;
            n_checks++;
            if (xfer_count !== 8'(exp_cnt) || xfer_count_w !== 2'(exp_cnt) || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_count got %0d/%0d busy=%b want %0d/%0d 0", xfer_count, xfer_count_w, busy, exp_cnt % 256, exp_cnt % 4);
            end
        end
    endtask
    initial begin
        test_reset();
        test_single();
        test_contention();
        test_data_stability();
        test_early_drop();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
